// File: rtl/barrett_sb_pkg.sv
// Shared types, default sizes and helpers for the Barrett result scoreboard.
package barrett_sb_pkg;

    localparam int unsigned SB_DATA_W  = 64;
    localparam int unsigned SB_DEPTH   = 16;
    localparam int unsigned SB_CNT_W   = 32;
    localparam int unsigned SB_TIMEOUT = 64;

    typedef enum logic [1:0] {
        SB_IDLE  = 2'd0,
        SB_RUN   = 2'd1,
        SB_DRAIN = 2'd2,
        SB_DONE  = 2'd3
    } sb_state_e;

    // Increment that sticks at the all-ones value of a 'width'-bit counter (width <= 64).
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value >= max_val) ? value : value + 64'd1;
    endfunction

endpackage

// File: rtl/sb_fifo.sv
// In-order expected-value queue: drop-on-full push, pop ignored when empty,
// combinational head; pointers carry one extra bit to tell full from empty.
module sb_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head_c,
    output logic             full_c,
    output logic             empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_c = (wr_ptr == rd_ptr);
    assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty_c;
    assign do_push = push && (!full_c || do_pop);
    assign head_c  = mem[rd_ptr[AW-1:0]];

    // Pointer update; clear empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage write; contents need no reset since the pointers gate every read.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/barrett_result_scoreboard.sv
// In-order result checker for the pipelined Barrett reducer.
// Optional capture of the last failing result/expected pair: BARRETT_SB_CAPTURE_EN.
module barrett_result_scoreboard
    import barrett_sb_pkg::*;
#(
    parameter int unsigned DATA_W  = SB_DATA_W,
    parameter int unsigned DEPTH   = SB_DEPTH,
    parameter int unsigned CNT_W   = SB_CNT_W,
    parameter int unsigned TIMEOUT = SB_TIMEOUT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              issue_i,
    input  logic [DATA_W-1:0] expected_i,
    input  logic              end_i,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] result_i,
    output logic [CNT_W-1:0]  pass_cnt_o,
    output logic [CNT_W-1:0]  fail_cnt_o,
    output logic [CNT_W-1:0]  first_fail_idx_o,
    output logic              mismatch_o,
    output logic              overflow_o,
    output logic              underflow_o,
    output logic              timeout_o,
    output logic              done_o,
    output logic              all_pass_o,
    output logic [DATA_W-1:0] last_bad_result_o,
    output logic [DATA_W-1:0] last_bad_expected_o
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    sb_state_e          state_q;
    sb_state_e          state_nxt;
    logic [IDLE_W-1:0]  idle_q;
    logic [IDLE_W-1:0]  idle_nxt;
    logic [CNT_W-1:0]   idx_q;
    logic [CNT_W-1:0]   idx_nxt;
    logic [CNT_W-1:0]   pass_nxt;
    logic [CNT_W-1:0]   fail_nxt;
    logic [CNT_W-1:0]   first_nxt;
    logic               mism_nxt;
    logic               ovf_nxt;
    logic               unf_nxt;
    logic               to_nxt;
    logic               done_nxt;
    logic               all_pass_nxt;
    logic               active_c;
    logic               push_c;
    logic               pop_c;
    logic               fail_ev_c;
    logic [DATA_W-1:0]  fifo_head;
    logic               fifo_full;
    logic               fifo_empty;

    sb_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .clear   (clear_i),
        .push    (push_c),
        .pop     (pop_c),
        .din     (expected_i),
        .head_c  (fifo_head),
        .full_c  (fifo_full),
        .empty_c (fifo_empty)
    );

    // Next-state, compare and statistics update; clear overrides everything.
    always_comb begin
        state_nxt = state_q;
        idle_nxt  = idle_q;
        idx_nxt   = idx_q;
        pass_nxt  = pass_cnt_o;
        fail_nxt  = fail_cnt_o;
        first_nxt = first_fail_idx_o;
        ovf_nxt   = overflow_o;
        unf_nxt   = underflow_o;
        to_nxt    = timeout_o;
        mism_nxt  = 1'b0;
        push_c    = 1'b0;
        pop_c     = 1'b0;
        fail_ev_c = 1'b0;
        active_c  = (state_q == SB_RUN) || (state_q == SB_DRAIN);

        if (clear_i) begin
            state_nxt = SB_IDLE;
            idle_nxt  = '0;
            idx_nxt   = '0;
            pass_nxt  = '0;
            fail_nxt  = '0;
            first_nxt = '0;
            ovf_nxt   = 1'b0;
            unf_nxt   = 1'b0;
            to_nxt    = 1'b0;
        end else begin
            pop_c  = valid_i && active_c && !fifo_empty;
            push_c = issue_i && (state_q != SB_DONE);
            if (push_c && fifo_full && !pop_c) ovf_nxt = 1'b1;

            if (valid_i) begin
                idx_nxt = CNT_W'(sat_inc(64'(idx_q), CNT_W));
                if (pop_c) begin
                    if (fifo_head == result_i) begin
                        pass_nxt = CNT_W'(sat_inc(64'(pass_cnt_o), CNT_W));
                    end else begin
                        fail_ev_c = 1'b1;
                        mism_nxt  = 1'b1;
                    end
                end else begin
                    fail_ev_c = 1'b1;
                    unf_nxt   = 1'b1;
                end
            end

            if (fail_ev_c) begin
                fail_nxt = CNT_W'(sat_inc(64'(fail_cnt_o), CNT_W));
                if (fail_cnt_o == '0) first_nxt = idx_q;
            end

            case (state_q)
                SB_IDLE: begin
                    if (issue_i) state_nxt = SB_RUN;
                end
                SB_RUN: begin
                    if (end_i) begin
                        state_nxt = SB_DRAIN;
                        idle_nxt  = '0;
                    end
                end
                SB_DRAIN: begin
                    if (fifo_empty && !valid_i) begin
                        state_nxt = SB_DONE;
                    end else if (valid_i) begin
                        idle_nxt = '0;
                    end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                        state_nxt = SB_DONE;
                        to_nxt    = 1'b1;
                    end else begin
                        idle_nxt = idle_q + IDLE_W'(1);
                    end
                end
                default: state_nxt = SB_DONE;
            endcase
        end

        done_nxt     = (state_nxt == SB_DONE);
        all_pass_nxt = done_nxt && (fail_nxt == '0) && !ovf_nxt && !unf_nxt && !to_nxt;
    end

    // State and registered statistics.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= SB_IDLE;
            idle_q           <= '0;
            idx_q            <= '0;
            pass_cnt_o       <= '0;
            fail_cnt_o       <= '0;
            first_fail_idx_o <= '0;
            mismatch_o       <= 1'b0;
            overflow_o       <= 1'b0;
            underflow_o      <= 1'b0;
            timeout_o        <= 1'b0;
            done_o           <= 1'b0;
            all_pass_o       <= 1'b0;
        end else begin
            state_q          <= state_nxt;
            idle_q           <= idle_nxt;
            idx_q            <= idx_nxt;
            pass_cnt_o       <= pass_nxt;
            fail_cnt_o       <= fail_nxt;
            first_fail_idx_o <= first_nxt;
            mismatch_o       <= mism_nxt;
            overflow_o       <= ovf_nxt;
            underflow_o      <= unf_nxt;
            timeout_o        <= to_nxt;
            done_o           <= done_nxt;
            all_pass_o       <= all_pass_nxt;
        end
    end

`ifdef BARRETT_SB_CAPTURE_EN
    // Capture the most recent failing compare; underflows leave it untouched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_bad_result_o   <= '0;
            last_bad_expected_o <= '0;
        end else if (clear_i) begin
            last_bad_result_o   <= '0;
            last_bad_expected_o <= '0;
        end else if (mism_nxt) begin
            last_bad_result_o   <= result_i;
            last_bad_expected_o <= fifo_head;
        end
    end
`else
    assign last_bad_result_o   = '0;
    assign last_bad_expected_o = '0;
`endif

endmodule

// File: tb/tb_barrett_result_scoreboard.sv
// Self-checking bench for barrett_result_scoreboard: table vectors, directed
// corner sequences and random traffic against a queue-based reference model.
module tb_barrett_result_scoreboard;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned TIMEOUT = 64;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE  = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              issue = 1'b0;
    logic [DATA_W-1:0] expv = '0;
    logic              endp = 1'b0;
    logic              clr = 1'b0;
    logic              valid = 1'b0;
    logic [DATA_W-1:0] result = '0;
    logic [CNT_W-1:0]  pass_cnt;
    logic [CNT_W-1:0]  fail_cnt;
    logic [CNT_W-1:0]  first_idx;
    logic              mismatch;
    logic              overflow;
    logic              underflow;
    logic              timeout;
    logic              done;
    logic              all_pass;
    logic [DATA_W-1:0] bad_res;
    logic [DATA_W-1:0] bad_exp;

    int checks   = 0;
    int failures = 0;

    barrett_result_scoreboard #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .issue_i            (issue),
        .expected_i         (expv),
        .end_i              (endp),
        .clear_i            (clr),
        .valid_i            (valid),
        .result_i           (result),
        .pass_cnt_o         (pass_cnt),
        .fail_cnt_o         (fail_cnt),
        .first_fail_idx_o   (first_idx),
        .mismatch_o         (mismatch),
        .overflow_o         (overflow),
        .underflow_o        (underflow),
        .timeout_o          (timeout),
        .done_o             (done),
        .all_pass_o         (all_pass),
        .last_bad_result_o  (bad_res),
        .last_bad_expected_o(bad_exp)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] mq[$];
    int                m_state;
    int                m_idle;
    logic [CNT_W-1:0]  m_pass, m_fail, m_idx, m_first;
    bit                m_mism, m_ovf, m_unf, m_to;
    logic [DATA_W-1:0] m_bad_res, m_bad_exp;

    function automatic logic [CNT_W-1:0] msat(input logic [CNT_W-1:0] x);
        return (x == '1) ? x : x + CNT_W'(1);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_state = M_IDLE; m_idle = 0;
        m_pass = '0; m_fail = '0; m_idx = '0; m_first = '0;
        m_mism = 0; m_ovf = 0; m_unf = 0; m_to = 0;
        m_bad_res = '0; m_bad_exp = '0;
    endtask

    task automatic model_step();
        logic [DATA_W-1:0] head;
        bit empty_pre, do_pop, fail_ev;
        m_mism = 0;
        if (clr) begin
            model_reset();
            return;
        end
        empty_pre = (mq.size() == 0);
        head      = empty_pre ? '0 : mq[0];
        do_pop    = valid && (m_state == M_RUN || m_state == M_DRAIN) && !empty_pre;
        fail_ev   = 0;
        if (valid) begin
            if (do_pop) begin
                if (result == head) m_pass = msat(m_pass);
                else begin
                    fail_ev = 1;
                    m_mism  = 1;
`ifdef BARRETT_SB_CAPTURE_EN
                    m_bad_res = result;
                    m_bad_exp = head;
`endif
                end
            end else begin
                fail_ev = 1;
                m_unf   = 1;
            end
            if (fail_ev) begin
                if (m_fail == '0) m_first = m_idx;
                m_fail = msat(m_fail);
            end
            m_idx = msat(m_idx);
        end
        if (do_pop) void'(mq.pop_front());
        if (issue && m_state != M_DONE) begin
            if (mq.size() < DEPTH) mq.push_back(expv);
            else m_ovf = 1;
        end
        case (m_state)
            M_IDLE:  if (issue) m_state = M_RUN;
            M_RUN:   if (endp) begin m_state = M_DRAIN; m_idle = 0; end
            M_DRAIN: begin
                if (empty_pre && !valid) m_state = M_DONE;
                else if (valid) m_idle = 0;
                else begin
                    m_idle++;
                    if (m_idle >= TIMEOUT) begin m_state = M_DONE; m_to = 1; end
                end
            end
            default: ;
        endcase
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic check_all();
        bit m_done;
        m_done = (m_state == M_DONE);
        chk("pass_cnt",  64'(pass_cnt),  64'(m_pass));
        chk("fail_cnt",  64'(fail_cnt),  64'(m_fail));
        chk("first_idx", 64'(first_idx), 64'(m_first));
        chk("mismatch",  64'(mismatch),  64'(m_mism));
        chk("overflow",  64'(overflow),  64'(m_ovf));
        chk("underflow", 64'(underflow), 64'(m_unf));
        chk("timeout",   64'(timeout),   64'(m_to));
        chk("done",      64'(done),      64'(m_done));
        chk("all_pass",  64'(all_pass),
            64'(m_done && m_fail == '0 && !m_ovf && !m_unf && !m_to));
        chk("bad_res",   64'(bad_res),   64'(m_bad_res));
        chk("bad_exp",   64'(bad_exp),   64'(m_bad_exp));
    endtask

    task automatic step(input bit i_iss, input logic [DATA_W-1:0] i_exp, input bit i_end,
                        input bit i_clr, input bit i_val, input logic [DATA_W-1:0] i_res);
        issue = i_iss; expv = i_exp; endp = i_end; clr = i_clr; valid = i_val; result = i_res;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle_step();
        step(0, '0, 0, 0, 0, '0);
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic [DATA_W-1:0] e;
        logic [DATA_W-1:0] r;
        logic [CNT_W-1:0]  want_pass;
        logic [CNT_W-1:0]  want_fail;
        bit                want_all_pass;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{64'h1, 64'h1, 1, 0, 1};
        vecs[1] = '{64'h0, 64'h0, 1, 0, 1};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 0};
        vecs[4] = '{64'h8000_0000_0000_0000, 64'h0, 0, 1, 0};
        vecs[5] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF1, 0, 1, 0};
        vecs[6] = '{64'h0, 64'h8000_0000_0000_0000, 0, 1, 0};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Single-transaction runs from the table.
        foreach (vecs[v]) begin
            step(0, '0, 0, 1, 0, '0);
            step(1, vecs[v].e, 0, 0, 0, '0);
            step(0, '0, 1, 0, 0, '0);
            step(0, '0, 0, 0, 1, vecs[v].r);
            chk("vec_mismatch", 64'(mismatch), 64'(vecs[v].want_fail));
            idle_step();
            chk("vec_done", 64'(done), 64'd1);
            chk("vec_pass", 64'(pass_cnt), 64'(vecs[v].want_pass));
            chk("vec_fail", 64'(fail_cnt), 64'(vecs[v].want_fail));
            chk("vec_all_pass", 64'(all_pass), 64'(vecs[v].want_all_pass));
`ifdef BARRETT_SB_CAPTURE_EN
            if (vecs[v].want_fail != '0) chk("vec_bad_res", bad_res, vecs[v].r);
`endif
        end

        // Four clean results.
        step(0, '0, 0, 1, 0, '0);
        for (int k = 1; k <= 4; k++) step(1, DATA_W'(k), 0, 0, 0, '0);
        step(0, '0, 1, 0, 0, '0);
        for (int k = 1; k <= 4; k++) step(0, '0, 0, 0, 1, DATA_W'(k));
        idle_step();
        chk("clean_pass", 64'(pass_cnt), 64'd4);
        chk("clean_fail", 64'(fail_cnt), 64'd0);
        chk("clean_done", 64'(done), 64'd1);
        chk("clean_all_pass", 64'(all_pass), 64'd1);

        // Third result wrong.
        step(0, '0, 0, 1, 0, '0);
        for (int k = 1; k <= 4; k++) step(1, DATA_W'(k), 0, 0, 0, '0);
        step(0, '0, 1, 0, 0, '0);
        step(0, '0, 0, 0, 1, 64'h1);
        step(0, '0, 0, 0, 1, 64'h2);
        step(0, '0, 0, 0, 1, 64'h5);
        chk("bad3_pulse", 64'(mismatch), 64'd1);
        step(0, '0, 0, 0, 1, 64'h4);
        chk("bad3_pulse_end", 64'(mismatch), 64'd0);
        idle_step();
        chk("bad3_fail", 64'(fail_cnt), 64'd1);
        chk("bad3_first_idx", 64'(first_idx), 64'd2);
        chk("bad3_all_pass", 64'(all_pass), 64'd0);
`ifdef BARRETT_SB_CAPTURE_EN
        chk("bad3_res", bad_res, 64'h5);
        chk("bad3_exp", bad_exp, 64'h3);
`endif

        // Overflow: 17 issues into a 16-deep queue, then 16 results.
        step(0, '0, 0, 1, 0, '0);
        for (int k = 1; k <= 17; k++) step(1, DATA_W'(k), 0, 0, 0, '0);
        chk("ovf_flag", 64'(overflow), 64'd1);
        for (int k = 1; k <= 16; k++) step(0, '0, 0, 0, 1, DATA_W'(k));
        chk("ovf_pass", 64'(pass_cnt), 64'd16);
        step(0, '0, 1, 0, 0, '0);
        idle_step();
        chk("ovf_empty_done", 64'(done), 64'd1);
        chk("ovf_fail", 64'(fail_cnt), 64'd0);

        // Full queue with simultaneous push and pop: accepted, no overflow.
        step(0, '0, 0, 1, 0, '0);
        for (int k = 1; k <= 16; k++) step(1, DATA_W'(k), 0, 0, 0, '0);
        step(1, 64'd100, 0, 0, 1, 64'd1);
        chk("full_pp_ovf", 64'(overflow), 64'd0);
        for (int k = 2; k <= 16; k++) step(0, '0, 0, 0, 1, DATA_W'(k));
        step(0, '0, 0, 0, 1, 64'd100);
        chk("full_pp_pass", 64'(pass_cnt), 64'd17);

        // Underflow: push and pop together on an empty queue, then empty in RUN.
        step(0, '0, 0, 1, 0, '0);
        step(1, 64'h7, 0, 0, 1, 64'h9215_3524);
        chk("unf_flag", 64'(underflow), 64'd1);
        chk("unf_fail", 64'(fail_cnt), 64'd1);
        chk("unf_pass", 64'(pass_cnt), 64'd0);
        step(0, '0, 0, 0, 1, 64'h7);
        chk("unf_stored", 64'(pass_cnt), 64'd1);
        step(0, '0, 0, 0, 1, 64'h9215_3524);
        chk("unf_run_fail", 64'(fail_cnt), 64'd2);

        // Drain timeout.
        step(0, '0, 0, 1, 0, '0);
        step(1, 64'h11, 0, 0, 0, '0);
        step(1, 64'h22, 0, 0, 0, '0);
        step(0, '0, 1, 0, 0, '0);
        for (int k = 0; k < 3 * TIMEOUT && !done; k++) idle_step();
        chk("to_flag", 64'(timeout), 64'd1);
        chk("to_done", 64'(done), 64'd1);
        chk("to_all_pass", 64'(all_pass), 64'd0);

        // Reset with entries outstanding, then clear out of DONE.
        step(0, '0, 0, 1, 0, '0);
        for (int k = 1; k <= 5; k++) step(1, DATA_W'(k), 0, 0, 0, '0);
        step(0, '0, 0, 0, 1, 64'hDEAD);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 64'h3, 0, 0, 0, '0);
        step(0, '0, 1, 0, 0, '0);
        step(0, '0, 0, 0, 1, 64'h3);
        idle_step();
        chk("fresh_done", 64'(done), 64'd1);
        chk("fresh_pass", 64'(pass_cnt), 64'd1);
        step(0, '0, 0, 1, 0, '0);
        chk("clr_pass", 64'(pass_cnt), 64'd0);
        chk("clr_done", 64'(done), 64'd0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bit r_iss, r_end, r_clr, r_val;
            logic [DATA_W-1:0] r_res;
            r_iss = ($urandom_range(0, 99) < 35);
            r_val = ($urandom_range(0, 99) < 30);
            r_end = ($urandom_range(0, 99) < 3);
            r_clr = ($urandom_range(0, 199) < 2);
            if (mq.size() != 0 && $urandom_range(0, 4) != 0) r_res = mq[0];
            else r_res = {$urandom, $urandom};
            step(r_iss, {$urandom, $urandom}, r_end, r_clr, r_val, r_res);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/barrett_result_scoreboard.md
Name: barrett_result_scoreboard

Overview:
- Hardware result checker that sits on the output side of the pipelined Barrett reducer.
- At each issue, the stimulus side pushes the expected residue (x mod m) into an in-order queue.
- On every reducer valid, the block pops the queue head and compares it with the reducer result, keeping pass/fail statistics.
- It gives on-chip and FPGA self-check of the reduction pipeline without a software testbench.

Parameters:
- DATA_W, 64, width of expected and result words.
- DEPTH, 16, expected-queue entries; must be a power of 2 and at least 2.
- CNT_W, 32, width of pass/fail counters and the fail index.
- TIMEOUT, 64, idle cycles allowed in DRAIN with no result before aborting.

Ports:
- clk_i  in  1  rising-edge clock.
- rst_ni  in  1  asynchronous active-low reset.
- issue_i  in  1  operand issued to the reducer this cycle; push expected_i.
- expected_i  in  DATA_W  reference residue for the issued operand.
- end_i  in  1  pulse: no further issues will follow.
- clear_i  in  1  synchronous clear of stats and queue; return to IDLE.
- valid_i  in  1  reducer result valid.
- result_i  in  DATA_W  reducer result.
- pass_cnt_o  out  CNT_W  matching results.
- fail_cnt_o  out  CNT_W  mismatching results plus underflows.
- first_fail_idx_o  out  CNT_W  compare index of the first failure.
- mismatch_o  out  1  one-cycle pulse, registered, the cycle after a failing compare.
- overflow_o  out  1  sticky: an issue was dropped because the queue was full.
- underflow_o  out  1  sticky: valid_i arrived with the queue empty.
- timeout_o  out  1  sticky: DRAIN timed out.
- done_o  out  1  level; high in DONE.
- all_pass_o  out  1  done_o and fail_cnt_o==0 and no sticky error flag set.
- last_bad_result_o  out  DATA_W  see Optional Feature.
- last_bad_expected_o  out  DATA_W  see Optional Feature.

Behaviour:
- Reset (async, rst_ni low): every output reads 0; FIFO pointers 0; compare index 0; state IDLE.
- States:
  - IDLE: transitions to RUN on issue_i.
  - RUN: transitions to DRAIN on end_i.
  - DRAIN: transitions to DONE when the queue is empty and no valid_i arrives this cycle, or when the idle counter reaches TIMEOUT (set timeout_o).
  - DONE: holds until clear_i.
- clear_i takes priority over every other input in every state: counters, flags, queue and index go to 0; state goes to IDLE.
- Push: issue_i pushes expected_i in IDLE, RUN and DRAIN (a late issue is still accepted); ignored in DONE.
- Pop and compare: valid_i in RUN or DRAIN pops the head and compares it with result_i over the full DATA_W.
  - Match: pass_cnt increments.
  - Mismatch: fail_cnt increments, mismatch_o pulses next cycle, and first_fail_idx_o latches the index on the first failure only.
- The compare index increments on every valid_i, including underflows.
- valid_i in IDLE or DONE is treated as an underflow.
- Same-cycle push and pop: the compare uses the current head only; there is no bypass of the entry being pushed.
  - If the queue is empty, that cycle is an underflow (fail_cnt+1, underflow_o set) and the pushed entry is still stored.
  - If the queue is full, simultaneous push and pop are both accepted and occupancy is unchanged.
- Full queue with push and no pop: the entry is dropped and overflow_o is set.
- Counters saturate at all-ones; they do not wrap.
- Pointers are log2(DEPTH)+1 bits wide; the extra bit distinguishes full from empty.
- The DRAIN idle counter resets on every valid_i.
- Outputs are registered; statistics are visible one cycle after the compare.
- Reset mid-operation discards outstanding entries with no error flag.

Optional Feature:
- Macro BARRETT_SB_CAPTURE_EN.
- Defined: on every mismatch, last_bad_result_o and last_bad_expected_o register result_i and the queue head (last failure wins); clear_i and reset zero them. Underflows do not update these registers.
- Undefined: both ports are tied to 0 and no capture registers are synthesized.

Decomposition:
- Package barrett_sb_pkg holds:
  - the state enum sb_state_e {SB_IDLE, SB_RUN, SB_DRAIN, SB_DONE};
  - default DATA_W, DEPTH, CNT_W and TIMEOUT localparams;
  - the saturating-increment function.
- Sub-module sb_fifo: a synchronous FIFO parameterised by width and depth, with push/pop/full/empty/head ports and drop-on-full behaviour.

Test Plan:
- Issue expected values 0x1, 0x2, 0x3, 0x4; pulse end_i; return results 0x1..0x4 → pass_cnt=4, fail_cnt=0, done_o=1, all_pass_o=1.
- Same stream but third result is 0x5 → mismatch_o pulses once, fail_cnt=1, first_fail_idx_o=2, all_pass_o=0; with the macro defined, last_bad_result_o=0x5 and last_bad_expected_o=0x3.
- 17 issues with no valid_i (DEPTH=16) → overflow_o=1; after 16 correct results pass_cnt=16 and the queue is empty.
- valid_i with result 0x92153524 on an empty queue in RUN → underflow_o=1, fail_cnt=1, pass_cnt=0.
- Issue 2 entries, pulse end_i, then no valid_i for 64 cycles → timeout_o=1, done_o=1, all_pass_o=0.
- 5 entries outstanding, rst_ni low for 1 cycle → all outputs 0, IDLE; then clear_i in DONE of a fresh run → counters 0, IDLE.
